// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU issue path: function codes, op classes and sequencer states.
package alu_ctrl_pkg;

    localparam logic [3:0] F_ADD = 4'b1111;
    localparam logic [3:0] F_SUB = 4'b1110;
    localparam logic [3:0] F_AND = 4'b1101;
    localparam logic [3:0] F_OR  = 4'b1100;
    localparam logic [3:0] F_MUL = 4'b0001;
    localparam logic [3:0] F_DIV = 4'b0010;
    localparam logic [3:0] F_SLL = 4'b1010;
    localparam logic [3:0] F_SLR = 4'b1011;
    localparam logic [3:0] F_ROL = 4'b1000;
    localparam logic [3:0] F_ROR = 4'b1001;
    localparam logic [3:0] NOP   = 4'b0000;

    // {ALUOp1,ALUOp0} classes; 2'b11 is undefined.
    localparam logic [1:0] CLS_A = 2'b00;
    localparam logic [1:0] CLS_B = 2'b10;
    localparam logic [1:0] CLS_C = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MULDIV = 2'd2
    } state_t;

    function automatic logic funct_is_legal(input logic [3:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_MUL,
            F_DIV, F_SLL, F_SLR, F_ROL, F_ROR: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: op class plus function code to ALU control code and op kind.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic       aluop1,
    input  logic       aluop0,
    input  logic [3:0] funct,
    output logic [3:0] code,
    output logic       is_mul,
    output logic       is_div,
    output logic       legal
);

    always_comb begin
        code   = NOP;
        is_mul = 1'b0;
        is_div = 1'b0;
        legal  = 1'b0;
        case ({aluop1, aluop0})
            CLS_A: begin
                if (funct_is_legal(funct)) begin
                    legal  = 1'b1;
                    code   = funct;
                    is_mul = (funct == F_MUL);
                    is_div = (funct == F_DIV);
                end
            end
            // Classes B and C never look at funct, so an undriven funct is harmless.
            CLS_B: begin
                legal = 1'b1;
                code  = F_ADD;
            end
            CLS_C: begin
                legal = 1'b1;
                code  = F_SUB;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue controller between decode and the ALU: resolves the control code, runs
// single-cycle ops back to back and sequences multi-cycle MUL/DIV with a stall.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       ALUOp1,
    input  logic       ALUOp0,
    input  logic [3:0] funct,
    input  logic       flush,
    output logic [3:0] alu_ctrl,
    output logic       mul_start,
    output logic       div_start,
    output logic       stall,
    output logic       result_valid,
    output logic       illegal_op,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dec_code;
    logic             dec_is_mul;
    logic             dec_is_div;
    logic             dec_legal;
    logic             accept;

    alu_op_decode u_decode (
        .aluop1 (ALUOp1),
        .aluop0 (ALUOp0),
        .funct  (funct),
        .code   (dec_code),
        .is_mul (dec_is_mul),
        .is_div (dec_is_div),
        .legal  (dec_legal)
    );

    // Handshake: an op transfers on any rising edge where op_valid && op_ready;
    // the producer holds the op stable while op_ready is low. flush drops
    // op_ready in the same cycle so a flushed op is never taken.
    assign op_ready  = (state != ST_MULDIV) && !flush;
    assign accept    = op_valid && op_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            alu_ctrl     <= NOP;
            mul_start    <= 1'b0;
            div_start    <= 1'b0;
            stall        <= 1'b0;
            result_valid <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            mul_start    <= 1'b0;
            div_start    <= 1'b0;
            result_valid <= 1'b0;
            illegal_op   <= 1'b0;
            if (flush) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                stall    <= 1'b0;
                alu_ctrl <= NOP;
            end else if (state == ST_MULDIV) begin
                // The result appears the cycle after the count reaches zero.
                if (cnt == '0) begin
                    state        <= ST_IDLE;
                    stall        <= 1'b0;
                    result_valid <= 1'b1;
                    alu_ctrl     <= NOP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (accept) begin
                if (!dec_legal) begin
                    state      <= ST_IDLE;
                    illegal_op <= 1'b1;
                    alu_ctrl   <= NOP;
                end else if (dec_is_mul) begin
                    state     <= ST_MULDIV;
                    cnt       <= MUL_LOAD;
                    stall     <= 1'b1;
                    mul_start <= 1'b1;
                    alu_ctrl  <= dec_code;
                end else if (dec_is_div) begin
                    state     <= ST_MULDIV;
                    cnt       <= DIV_LOAD;
                    stall     <= 1'b1;
                    div_start <= 1'b1;
                    alu_ctrl  <= dec_code;
                end else begin
                    state        <= ST_EXEC;
                    result_valid <= 1'b1;
                    alu_ctrl     <= dec_code;
                end
            end else begin
                state    <= ST_IDLE;
                alu_ctrl <= NOP;
            end
        end
    end

endmodule
